// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the writeback-port arbiter; the age compare
// is also used by the ROB and LSU.
package wb_port_arbiter_pkg;

    localparam int ROB_IDX_W = 6;
    localparam int ROB_W     = ROB_IDX_W + 1;
    localparam int PREG_W    = 7;
    localparam int XLEN      = 32;

    // Layout-compatible with the WriteBackBus data bundle.
    typedef struct packed {
        logic              en;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] rd;
        logic [XLEN-1:0]   res;
    } wb_data_t;

    // True when a is younger than b; the wrap bit flips the sense of the
    // index compare once the ROB pointer has wrapped.
    function automatic logic younger(input logic [ROB_W-1:0] a,
                                     input logic [ROB_W-1:0] b);
        if (a[ROB_IDX_W] == b[ROB_IDX_W])
            return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
        else
            return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr.sv
// Round-robin multi-grant: picks up to PORT_NUM requesters starting at
// start_ptr, k-th pick goes to port k. Reusable for issue-queue select.
module rr_multi_grant #(
    parameter int REQ_NUM  = 4,
    parameter int PORT_NUM = 2,
    parameter int PTR_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic [REQ_NUM-1:0]                req,
    input  logic [PTR_W-1:0]                  start_ptr,
    output logic [REQ_NUM-1:0]                grant,
    output logic [PORT_NUM-1:0]               port_vld,
    output logic [PORT_NUM-1:0][PTR_W-1:0]    port_idx,
    output logic [PTR_W-1:0]                  next_ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(REQ_NUM - 1);

    // Scan with an explicit wrap so REQ_NUM need not be a power of two.
    always_comb begin
        logic [PTR_W-1:0] idx;
        int               cnt;
        grant    = '0;
        port_vld = '0;
        port_idx = '0;
        next_ptr = start_ptr;
        idx      = start_ptr;
        cnt      = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (req[idx] && cnt < PORT_NUM) begin
                grant[idx] = 1'b1;
                for (int p = 0; p < PORT_NUM; p++) begin
                    if (cnt == p) begin
                        port_vld[p] = 1'b1;
                        port_idx[p] = idx;
                    end
                end
                cnt      = cnt + 1;
                next_ptr = (idx == LAST) ? '0 : idx + PTR_W'(1);
            end
            idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares PORT_NUM writeback ports among REQ_NUM variable-latency units,
// each with a one-entry holding buffer; redirect/flush squash younger work.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int REQ_NUM  = 4,
    parameter int PORT_NUM = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REQ_NUM-1:0]                req_valid,
    output logic [REQ_NUM-1:0]                req_ready,
    input  logic [REQ_NUM-1:0][ROB_W-1:0]     req_rob_idx,
    input  logic [REQ_NUM-1:0][PREG_W-1:0]    req_rd,
    input  logic [REQ_NUM-1:0][XLEN-1:0]      req_res,
    input  logic                              redirect_valid,
    input  logic [ROB_W-1:0]                  redirect_rob_idx,
    input  logic                              flush_all,
    output logic [PORT_NUM-1:0]               wb_en,
    output logic [PORT_NUM-1:0]               wb_we,
    output logic [PORT_NUM-1:0][ROB_W-1:0]    wb_rob_idx,
    output logic [PORT_NUM-1:0][PREG_W-1:0]   wb_rd,
    output logic [PORT_NUM-1:0][XLEN-1:0]     wb_res
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [REQ_NUM-1:0]                buf_v;
    logic [REQ_NUM-1:0][ROB_W-1:0]     buf_rob;
    logic [REQ_NUM-1:0][PREG_W-1:0]    buf_rd;
    logic [REQ_NUM-1:0][XLEN-1:0]      buf_res;
    logic [REQ_NUM-1:0]                kill_buf, kill_in, gnt_req, grant;
    logic [PORT_NUM-1:0]               port_vld, kill_out;
    logic [PORT_NUM-1:0][PTR_W-1:0]    port_idx;
    logic [PTR_W-1:0]                  rr_ptr, next_ptr;
    wb_data_t [PORT_NUM-1:0]           wb_q;
    logic [PORT_NUM-1:0]               wb_we_q;

    // Squash decisions for held and incoming entries; flush covers everything.
    always_comb begin
        kill_buf = '0;
        kill_in  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            kill_buf[i] = flush_all | (redirect_valid & younger(buf_rob[i], redirect_rob_idx));
            kill_in[i]  = flush_all | (redirect_valid & younger(req_rob_idx[i], redirect_rob_idx));
        end
    end

    // A slot frees when drained or squashed; squashed arrivals are acked and dropped.
    assign gnt_req   = buf_v & ~kill_buf;
    assign req_ready = ~buf_v | grant | kill_buf | kill_in;

    rr_multi_grant #(
        .REQ_NUM  (REQ_NUM),
        .PORT_NUM (PORT_NUM),
        .PTR_W    (PTR_W)
    ) u_rr (
        .req       (gnt_req),
        .start_ptr (rr_ptr),
        .grant     (grant),
        .port_vld  (port_vld),
        .port_idx  (port_idx),
        .next_ptr  (next_ptr)
    );

    // Holding buffers: a refill on the same edge as a drain keeps the new entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v   <= '0;
            buf_rob <= '0;
            buf_rd  <= '0;
            buf_res <= '0;
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (req_valid[i] && req_ready[i] && !kill_in[i]) begin
                    buf_v[i]   <= 1'b1;
                    buf_rob[i] <= req_rob_idx[i];
                    buf_rd[i]  <= req_rd[i];
                    buf_res[i] <= req_res[i];
                end else if (grant[i] || kill_buf[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances past the last granted requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr <= '0;
        else      rr_ptr <= next_ptr;
    end

    // Output registers; idle ports load all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q    <= '0;
            wb_we_q <= '0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (port_vld[p]) begin
                    wb_q[p].en      <= 1'b1;
                    wb_q[p].rob_idx <= buf_rob[port_idx[p]];
                    wb_q[p].rd      <= buf_rd[port_idx[p]];
                    wb_q[p].res     <= buf_res[port_idx[p]];
                    wb_we_q[p]      <= |buf_rd[port_idx[p]];
                end else begin
                    wb_q[p]    <= '0;
                    wb_we_q[p] <= 1'b0;
                end
            end
        end
    end

    // Registered results already on the bus are squashed in the same cycle;
    // write enable follows so a dead result can never write the regfile.
    always_comb begin
        kill_out   = '0;
        wb_en      = '0;
        wb_we      = '0;
        wb_rob_idx = '0;
        wb_rd      = '0;
        wb_res     = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            kill_out[p]   = flush_all | (redirect_valid & younger(wb_q[p].rob_idx, redirect_rob_idx));
            wb_en[p]      = wb_q[p].en & ~kill_out[p];
            wb_we[p]      = wb_we_q[p] & wb_q[p].en & ~kill_out[p];
            wb_rob_idx[p] = wb_q[p].rob_idx;
            wb_rd[p]      = wb_q[p].rd;
            wb_res[p]     = wb_q[p].res;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (REQ_NUM=4, PORT_NUM=2).
module tb_wb_port_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][6:0]  req_rob_idx;
    logic [3:0][6:0]  req_rd;
    logic [3:0][31:0] req_res;
    logic             redirect_valid;
    logic [6:0]       redirect_rob_idx;
    logic             flush_all;
    logic [1:0]       wb_en;
    logic [1:0]       wb_we;
    logic [1:0][6:0]  wb_rob_idx;
    logic [1:0][6:0]  wb_rd;
    logic [1:0][31:0] wb_res;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(.REQ_NUM(4), .PORT_NUM(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_rob_idx      (req_rob_idx),
        .req_rd           (req_rd),
        .req_res          (req_res),
        .redirect_valid   (redirect_valid),
        .redirect_rob_idx (redirect_rob_idx),
        .flush_all        (flush_all),
        .wb_en            (wb_en),
        .wb_we            (wb_we),
        .wb_rob_idx       (wb_rob_idx),
        .wb_rd            (wb_rd),
        .wb_res           (wb_res)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] rob, input logic [6:0] rd,
                           input logic [31:0] res);
        req_valid[i]   = 1'b1;
        req_rob_idx[i] = rob;
        req_rd[i]      = rd;
        req_res[i]     = res;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL reset_wb_en: got %b want 00", wb_en); end
        n_cmp++; if (wb_we !== 2'b00) begin n_err++; $display("FAIL reset_wb_we: got %b want 00", wb_we); end
        n_cmp++; if (wb_rob_idx !== 14'h0 || wb_rd !== 14'h0) begin n_err++; $display("FAIL reset_wb_idx: got %h/%h want 0", wb_rob_idx, wb_rd); end
        n_cmp++; if (wb_res !== 64'h0) begin n_err++; $display("FAIL reset_wb_res: got %h want 0", wb_res); end
        n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready: got %b want 1111", req_ready); end
        step;
        rst = 1'b1;
        step;
    endtask

    task automatic test_contention;
        for (int i = 0; i < 4; i++) set_req(i, 7'h20 + 7'(i), 7'(i + 1), 32'h100 + 32'(i));
        step;
        req_valid = '0;
        n_cmp++; if (req_ready !== 4'b0011) begin n_err++; $display("FAIL cont_ready1: got %b want 0011", req_ready); end
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL cont_idle: got %b want 00", wb_en); end
        step;
        n_cmp++; if (wb_en !== 2'b11) begin n_err++; $display("FAIL cont_en1: got %b want 11", wb_en); end
        n_cmp++; if (wb_rob_idx[0] !== 7'h20 || wb_rob_idx[1] !== 7'h21) begin n_err++; $display("FAIL cont_rob1: got %h %h want 20 21", wb_rob_idx[0], wb_rob_idx[1]); end
        n_cmp++; if (wb_rd[1] !== 7'd2 || wb_res[1] !== 32'h101) begin n_err++; $display("FAIL cont_pay1: got %h %h want 2 101", wb_rd[1], wb_res[1]); end
        n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL cont_ready2: got %b want 1111", req_ready); end
        step;
        n_cmp++; if (wb_en !== 2'b11 || wb_rob_idx[0] !== 7'h22 || wb_rob_idx[1] !== 7'h23) begin n_err++; $display("FAIL cont_rob2: got en %b %h %h want 11 22 23", wb_en, wb_rob_idx[0], wb_rob_idx[1]); end
        // rr_ptr back at 0: req0 must land on port 0 ahead of req3
        set_req(3, 7'h33, 7'd4, 32'h33);
        set_req(0, 7'h30, 7'd1, 32'h30);
        step;
        req_valid = '0;
        step;
        n_cmp++; if (wb_rob_idx[0] !== 7'h30 || wb_rob_idx[1] !== 7'h33) begin n_err++; $display("FAIL cont_ptr0: got %h %h want 30 33", wb_rob_idx[0], wb_rob_idx[1]); end
        step;
    endtask

    task automatic test_basic_latency;
        set_req(0, 7'h05, 7'd3, 32'hDEAD);
        step;
        req_valid = '0;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL basic_early: got %b want 00", wb_en); end
        step;
        n_cmp++; if (wb_en !== 2'b01 || wb_we !== 2'b01) begin n_err++; $display("FAIL basic_en: got en %b we %b want 01 01", wb_en, wb_we); end
        n_cmp++; if (wb_rob_idx[0] !== 7'h05 || wb_rd[0] !== 7'd3) begin n_err++; $display("FAIL basic_idx: got %h %h want 05 03", wb_rob_idx[0], wb_rd[0]); end
        n_cmp++; if (wb_res[0] !== 32'hDEAD || wb_res[1] !== 32'h0) begin n_err++; $display("FAIL basic_res: got %h %h want dead 0", wb_res[0], wb_res[1]); end
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL basic_after: got %b want 00", wb_en); end
    endtask

    task automatic test_streaming;
        for (int k = 0; k < 6; k++) begin
            set_req(2, 7'h30 + 7'(k), 7'd9, 32'(k));
            n_cmp++; if (req_ready[2] !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d: got %b want 1", k, req_ready[2]); end
            step;
            if (k >= 1) begin
                n_cmp++; if (wb_en !== 2'b01 || wb_res[0] !== 32'(k - 1)) begin n_err++; $display("FAIL stream_wb k=%0d: got %b %h want 01 %h", k, wb_en, wb_res[0], k - 1); end
            end
        end
        req_valid = '0;
        step;
        n_cmp++; if (wb_en !== 2'b01 || wb_res[0] !== 32'd5) begin n_err++; $display("FAIL stream_last: got %b %h want 01 5", wb_en, wb_res[0]); end
        step;
    endtask

    task automatic test_redirect;
        set_req(0, 7'h10, 7'd1, 32'h10);
        set_req(1, 7'h12, 7'd2, 32'h12);
        set_req(2, 7'h42, 7'd3, 32'h42);
        step;
        req_valid        = '0;
        redirect_valid   = 1'b1;
        redirect_rob_idx = 7'h10;
        #1;
        n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL redir_ready: got %b want 1111", req_ready); end
        step;
        redirect_valid = 1'b0;
        n_cmp++; if (wb_en !== 2'b01 || wb_rob_idx[0] !== 7'h10) begin n_err++; $display("FAIL redir_keep: got %b %h want 01 10", wb_en, wb_rob_idx[0]); end
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL redir_drop1: got %b want 00", wb_en); end
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL redir_drop2: got %b want 00", wb_en); end
        // registered result squashed combinationally, incoming younger req dropped
        set_req(1, 7'h15, 7'd5, 32'h55);
        step;
        req_valid = '0;
        step;
        n_cmp++; if (wb_en !== 2'b01 || wb_rob_idx[0] !== 7'h15) begin n_err++; $display("FAIL redir_out_pre: got %b %h want 01 15", wb_en, wb_rob_idx[0]); end
        redirect_valid   = 1'b1;
        redirect_rob_idx = 7'h14;
        set_req(0, 7'h16, 7'd6, 32'h66);
        #1;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL redir_out_kill: got %b want 00", wb_en); end
        n_cmp++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL redir_in_ack: got %b want 1", req_ready[0]); end
        step;
        redirect_valid = 1'b0;
        req_valid      = '0;
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL redir_in_drop: got %b want 00", wb_en); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) set_req(i, 7'h01 + 7'(i), 7'(i + 1), 32'hF0 + 32'(i));
        step;
        req_valid = '0;
        step;
        n_cmp++; if (wb_en !== 2'b11) begin n_err++; $display("FAIL flush_pre: got %b want 11", wb_en); end
        flush_all = 1'b1;
        set_req(2, 7'h08, 7'd8, 32'h88);
        #1;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL flush_now: got %b want 00", wb_en); end
        n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL flush_ack: got %b want 1111", req_ready); end
        step;
        flush_all = 1'b0;
        req_valid = '0;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL flush_next: got %b want 00", wb_en); end
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL flush_bufs: got %b want 00", wb_en); end
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL flush_late: got %b want 00", wb_en); end
    endtask

    task automatic test_rd_zero_and_reset;
        set_req(0, 7'h09, 7'd0, 32'h77);
        step;
        req_valid = '0;
        step;
        n_cmp++; if (wb_en !== 2'b01 || wb_we !== 2'b00) begin n_err++; $display("FAIL rd0: got en %b we %b want 01 00", wb_en, wb_we); end
        for (int i = 0; i < 4; i++) set_req(i, 7'h18 + 7'(i), 7'(i + 1), 32'hA0 + 32'(i));
        step;
        req_valid = '0;
        step;
        n_cmp++; if (wb_en !== 2'b11) begin n_err++; $display("FAIL rst_pre: got %b want 11", wb_en); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (wb_en !== 2'b00 || wb_we !== 2'b00) begin n_err++; $display("FAIL rst_async_en: got %b %b want 00 00", wb_en, wb_we); end
        n_cmp++; if (wb_rob_idx !== 14'h0 || wb_rd !== 14'h0 || wb_res !== 64'h0) begin n_err++; $display("FAIL rst_async_pay: got %h %h %h want 0", wb_rob_idx, wb_rd, wb_res); end
        n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL rst_async_ready: got %b want 1111", req_ready); end
        step;
        rst = 1'b1;
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL rst_release1: got %b want 00", wb_en); end
        step;
        n_cmp++; if (wb_en !== 2'b00) begin n_err++; $display("FAIL rst_release2: got %b want 00", wb_en); end
        set_req(3, 7'h2B, 7'd4, 32'hB3);
        set_req(1, 7'h29, 7'd2, 32'hB1);
        step;
        req_valid = '0;
        step;
        n_cmp++; if (wb_rob_idx[0] !== 7'h29 || wb_rob_idx[1] !== 7'h2B) begin n_err++; $display("FAIL rst_ptr0: got %h %h want 29 2b", wb_rob_idx[0], wb_rob_idx[1]); end
    endtask

    initial begin
        rst              = 1'b0;
        req_valid        = '0;
        req_rob_idx      = '0;
        req_rd           = '0;
        req_res          = '0;
        redirect_valid   = 1'b0;
        redirect_rob_idx = '0;
        flush_all        = 1'b0;
        test_reset;
        test_contention;
        test_basic_latency;
        test_streaming;
        test_redirect;
        test_flush;
        test_rd_zero_and_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares PORT_NUM writeback-bus ports among REQ_NUM variable-latency requesters (CSR, MUL, DIV, FPU-move), replacing fixed "CSR steals ALU port 1" muxing.
- Each requester has a one-entry holding buffer with valid/ready backpressure.
- Round-robin grant fills the ports; outputs are registered and drive WriteBackBus ports.
- Redirect and flush kill younger in-flight results.

Parameters:
- REQ_NUM, 4, number of requesters.
- PORT_NUM, 2, writeback ports owned by this arbiter; PORT_NUM <= REQ_NUM.
- ROB_IDX_W, 6, ROB index width excluding the wrap bit.
- PREG_W, 7, physical register index width.
- XLEN, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  REQ_NUM  requester holds a result.
- req_ready  out  REQ_NUM  holding buffer can accept this cycle.
- req_rob_idx  in  REQ_NUM x (ROB_IDX_W+1)  {wrap bit, index}.
- req_rd  in  REQ_NUM x PREG_W  destination preg.
- req_res  in  REQ_NUM x XLEN  result.
- redirect_valid  in  1  branch redirect.
- redirect_rob_idx  in  ROB_IDX_W+1  redirecting instruction.
- flush_all  in  1  exception/full flush.
- wb_en  out  PORT_NUM  port carries a result.
- wb_we  out  PORT_NUM  register write enable, = (rd != 0).
- wb_rob_idx  out  PORT_NUM x (ROB_IDX_W+1)  ROB index.
- wb_rd  out  PORT_NUM x PREG_W  destination.
- wb_res  out  PORT_NUM x XLEN  result.

Behaviour:
- Reset (rst=0, async): all buffer valid bits = 0, rr_ptr = 0; wb_en, wb_we, wb_rob_idx, wb_rd, wb_res = 0.
- req_ready[i] = !buf_v[i] | grant[i], combinational from current-cycle grant.
  - A transfer occurs when req_valid & req_ready at the edge.
  - A new request may enter the buffer on the same edge its old entry is granted.
- Grant selection (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo REQ_NUM.
  - Grant the first PORT_NUM with buf_v=1 and not killed this cycle.
  - The k-th grant maps to port k, so ports fill low-first.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted + 1) mod REQ_NUM; otherwise unchanged.
- Starvation bound: a valid, unkilled buffer is granted within ceil(REQ_NUM/PORT_NUM) cycles.
- Latency: request accepted at edge E0; the buffer is visible in cycle E0..E1; if granted in that cycle, the wb_* registers load at E1. Minimum latency is 1 cycle from acceptance to wb_en.
- Output register:
  - Ports with no grant load wb_en=0.
  - Payload fields also load 0, so idle ports show all-zero.
- Age rule: younger(a,b) = (a.wrap==b.wrap) ? a.idx > b.idx : a.idx < b.idx.
- Kill on redirect_valid:
  - Buffers, incoming requests, and registered outputs with younger(x, redirect_rob_idx) are dropped.
  - The redirecting index itself is kept.
  - A killed buffer clears next edge and is not granted this cycle.
  - A killed incoming request is acked (req_ready=1 toward it) but not stored.
  - A killed wb_* entry has wb_en forced to 0 combinationally in the same cycle.
- flush_all: clears all buffers and wb_en next edge, and suppresses the current wb_en combinationally; incoming requests are acked and dropped. flush_all dominates redirect.
- Simultaneous events:
  - Grant and refill of the same buffer: the new entry stays.
  - redirect with flush_all: flush_all wins.
- Reset mid-operation: all state cleared immediately; no partial writebacks appear after reset release.
- Index arithmetic is modulo REQ_NUM; REQ_NUM need not be a power of two (explicit wrap compare).

Decomposition:
- Shared package:
  - WBData-compatible struct {en, robIdx, rd, res}.
  - The younger() age-compare function, which ROB/LSU also need.
  - Widths derived from global defines.
- Sub-module rr_multi_grant (REQ_NUM, PORT_NUM): inputs request vector and start pointer; outputs grant vector, per-port requester index, and next pointer. It is reusable for issue queues.

Test Plan:
- Basic latency (REQ_NUM=4, PORT_NUM=2): req0 only, rob 0x05, rd 3, res 0xDEAD → one cycle later wb_en=01, wb_we[0]=1, wb_rob_idx[0]=0x05, wb_res[0]=0xDEAD.
- Contention with rr_ptr=0, all four buffers full → cycle 1 grants 0,1 on ports 0,1; cycle 2 grants 2,3; rr_ptr returns to 0; req_ready rises for each granted buffer.
- Continuous streaming: req2 valid every cycle, others idle → one wb per cycle, req_ready[2] stays 1, no bubbles.
- Redirect: buffers hold rob {0,0x10}, {0,0x12}, {1,0x02}; redirect_rob_idx={0,0x10} → 0x10 is kept and written back; 0x12 and the wrap-bit-1 entry are dropped and never appear on wb_en.
- flush_all asserted the same cycle wb_en=11 is registered → wb_en reads 00 that cycle and next; all buffers empty; an incoming req is acked and never written back.
- rd=0 request → wb_en=1, wb_we=0. Then rst driven low mid-stream → all outputs 0 asynchronously, rr_ptr=0 after release.
